// File: rtl/gpu_sm_copy_vram_to_cpu_gen.sv
// VRAM->CPU rectangle copy engine: scans a WxH rect, repacks MEM_PIX-pixel VRAM words into 32-bit pixel pairs.
// Define GPU_COPYVC_PREFETCH_EN for two outstanding reads and a 2*MEM_PIX+1 pixel repack buffer.
module gpu_sm_copy_vram_to_cpu_gen #(
    parameter int MEM_PIX = 2,
`ifdef GPU_COPYVC_PREFETCH_EN
    parameter int BUF_PIX = 2 * MEM_PIX + 1
`else
    parameter int BUF_PIX = MEM_PIX + 1
`endif
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    i_activate,
    input  logic [9:0]              i_srcX,
    input  logic [8:0]              i_srcY,
    input  logic [9:0]              i_width,
    input  logic [8:0]              i_height,
    output logic                    o_active,
    output logic                    o_exitSig,
    output logic                    o_read,
    output logic [9:0]              o_readX,
    output logic [8:0]              o_readY,
    input  logic                    i_readACK,
    input  logic [MEM_PIX*16-1:0]   i_readData,
    input  logic                    i_canPush,
    input  logic                    i_outFIFO_empty,
    output logic                    o_writeFIFOOut,
    output logic [31:0]             o_pairPixelToCPU
);
    localparam int OW = $clog2(MEM_PIX);
    localparam int CW = $clog2(BUF_PIX + 1) + 1;
`ifdef GPU_COPYVC_PREFETCH_EN
    localparam int QD = 2;
`else
    localparam int QD = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t         r_state;
    logic           r_act_d;
    logic [9:0]     r_srcX, r_curX;
    logic [8:0]     r_curY;
    logic [10:0]    r_width, r_lineLeft;
    logic [19:0]    r_fetchLeft, r_pixLeft;
    logic [OW-1:0]  r_qOff [QD];
    logic [CW-1:0]  r_qN [QD];
    logic [1:0]     r_pend;
    logic [CW-1:0]  r_count, r_resv;
    logic [15:0]    r_buf [BUF_PIX];

    logic [OW-1:0]  w_off;
    logic [10:0]    w_rem, w_n11, w_wEff;
    logic [9:0]     w_hEff;
    logic [20:0]    w_area;
    logic [CW-1:0]  w_n, w_free, w_pop, w_ackN, w_keep;
    logic           w_fetch, w_ack;
    logic [1:0]     w_wrIdx;
    logic [15:0]    w_bufNext [BUF_PIX];

    assign w_off   = r_curX[OW-1:0];
    assign w_rem   = 11'(MEM_PIX) - 11'(w_off);
    assign w_n11   = (w_rem < r_lineLeft) ? w_rem : r_lineLeft;
    assign w_n     = w_n11[CW-1:0];
    assign w_free  = CW'(BUF_PIX) - r_count - r_resv;
    assign w_fetch = (r_state == S_RUN) && (r_pend < 2'(QD)) && (r_fetchLeft != 20'd0)
                     && (w_free >= CW'(MEM_PIX));
    assign w_ack   = (r_state == S_RUN) && i_readACK && (r_pend != 2'd0);
    assign w_ackN  = w_ack ? r_qN[0] : '0;
    assign w_wrIdx = r_pend - {1'b0, w_ack};
    assign w_keep  = r_count - w_pop;
    assign w_wEff  = {i_width == 10'd0, i_width};
    assign w_hEff  = {i_height == 9'd0, i_height};
    assign w_area  = 21'(w_wEff) * 21'(w_hEff);

    always_comb begin
        w_pop = '0;
        if (r_state == S_RUN && i_canPush) begin
            if (r_count >= CW'(2))
                w_pop = CW'(2);
            else if (r_count == CW'(1) && r_pixLeft == 20'd1)
                w_pop = CW'(1);
        end
    end

    // Buffer is a shift queue: survivors move down by the pop count, ACK pixels land right behind them.
    always_comb begin : buf_next
        int k;
        int idx;
        k   = 0;
        idx = 0;
        for (int j = 0; j < BUF_PIX; j++) begin
            w_bufNext[j] = r_buf[j];
            k   = j + int'(w_pop);
            idx = int'(r_qOff[0]) + j - int'(w_keep);
            if (CW'(j) < w_keep) begin
                if (k < BUF_PIX)
                    w_bufNext[j] = r_buf[k];
            end else if (CW'(j) < w_keep + w_ackN) begin
                if (idx >= 0 && idx < MEM_PIX)
                    w_bufNext[j] = i_readData[idx*16 +: 16];
            end
        end
    end

    // NOTE: pixel storage has no reset; r_count alone says which entries are valid, so stale data is never read.
    always_ff @(posedge clk) begin
        r_buf <= w_bufNext;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state          <= S_IDLE;
            r_act_d          <= 1'b0;
            r_srcX           <= '0;
            r_curX           <= '0;
            r_curY           <= '0;
            r_width          <= '0;
            r_lineLeft       <= '0;
            r_fetchLeft      <= '0;
            r_pixLeft        <= '0;
            r_pend           <= '0;
            r_count          <= '0;
            r_resv           <= '0;
            for (int i = 0; i < QD; i++) begin
                r_qOff[i] <= '0;
                r_qN[i]   <= '0;
            end
            o_active         <= 1'b0;
            o_exitSig        <= 1'b0;
            o_read           <= 1'b0;
            o_readX          <= '0;
            o_readY          <= '0;
            o_writeFIFOOut   <= 1'b0;
            o_pairPixelToCPU <= '0;
        end else begin
            r_act_d        <= i_activate;
            o_read         <= 1'b0;
            o_writeFIFOOut <= 1'b0;
            o_exitSig      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_activate && !r_act_d) begin
                        r_state  <= S_LOAD;
                        o_active <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_srcX      <= i_srcX;
                    r_curX      <= i_srcX;
                    r_curY      <= i_srcY;
                    r_width     <= w_wEff;
                    r_lineLeft  <= w_wEff;
                    r_fetchLeft <= w_area[19:0];
                    r_pixLeft   <= w_area[19:0];
                    r_pend      <= '0;
                    r_count     <= '0;
                    r_resv      <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    r_count   <= r_count - w_pop + w_ackN;
                    r_resv    <= r_resv - w_ackN + (w_fetch ? w_n : '0);
                    r_pend    <= r_pend - {1'b0, w_ack} + {1'b0, w_fetch};
                    r_pixLeft <= r_pixLeft - 20'(w_pop);
                    for (int i = 0; i < QD; i++) begin
                        if (w_ack) begin
                            r_qOff[i] <= r_qOff[(i + 1 < QD) ? i + 1 : i];
                            r_qN[i]   <= r_qN[(i + 1 < QD) ? i + 1 : i];
                        end
                        if (w_fetch && 2'(i) == w_wrIdx) begin
                            r_qOff[i] <= w_off;
                            r_qN[i]   <= w_n;
                        end
                    end
                    if (w_pop != '0) begin
                        o_writeFIFOOut   <= 1'b1;
                        o_pairPixelToCPU <= {(w_pop == CW'(2)) ? r_buf[1] : 16'h0000, r_buf[0]};
                    end
                    if (w_fetch) begin
                        o_read      <= 1'b1;
                        o_readX     <= r_curX & ~10'(MEM_PIX - 1);
                        o_readY     <= r_curY;
                        r_fetchLeft <= r_fetchLeft - 20'(w_n11);
                        if (r_lineLeft == w_n11) begin
                            r_curX     <= r_srcX;
                            r_lineLeft <= r_width;
                            r_curY     <= r_curY + 9'd1;
                        end else begin
                            r_curX     <= r_curX + w_n11[9:0];
                            r_lineLeft <= r_lineLeft - w_n11;
                        end
                    end
                    if (r_pixLeft == 20'd0 && r_pend == 2'd0 && r_count == '0)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (i_outFIFO_empty) begin
                        r_state   <= S_IDLE;
                        o_active  <= 1'b0;
                        o_exitSig <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Abort wins over everything above; in-flight ACKs are then ignored in IDLE.
            if (r_state != S_IDLE && !i_activate) begin
                r_state        <= S_IDLE;
                o_active       <= 1'b0;
                o_exitSig      <= 1'b0;
                o_read         <= 1'b0;
                o_writeFIFOOut <= 1'b0;
                r_pend         <= '0;
                r_count        <= '0;
                r_resv         <= '0;
            end
        end
    end
endmodule
